// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin search used by the 8-way arbiter.
package mux8_arb_pkg;

   localparam int N    = 8;
   localparam int SELW = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // First set bit of req at or after start, wrapping modulo 8; scanned from the far end so the nearest hit wins.
   function automatic logic [SELW-1:0] next_rr(input logic [N-1:0] req, input logic [SELW-1:0] start);
      logic [SELW-1:0] idx;
      logic [SELW-1:0] cand;
      idx = start;
      for (int i = N - 1; i >= 0; i--) begin
         cand = start + SELW'(i);
         if (req[cand]) begin
            idx = cand;
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/downstream bundle of the 8-way round-robin arbiter.
interface mux8_rr_arbiter_if #(
   parameter int DW = 1
);
   logic [7:0]      req;
   logic [8*DW-1:0] din;
   logic            out_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [2:0]      sel;
   logic [7:0]      gnt;
   logic            busy;

   modport master (
      output req, din, out_ready,
      input  out_valid, out_data, sel, gnt, busy
   );

   modport slave (
      input  req, din, out_ready,
      output out_valid, out_data, sel, gnt, busy
   );
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational rotate/priority-find over 8 requests starting at a given index.
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] start,
   output logic [SELW-1:0] idx,
   output logic            any
);

   assign idx = next_rr(req, start);
   assign any = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin sequencer sharing one 8:1 mux among 8 requesters, with a bounded hold per owner.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 4
)(
   input  logic             clk,
   input  logic             rst,
   mux8_rr_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   state_e          state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] last_sel_q, last_sel_d;
   logic [3:0]      hold_cnt_q, hold_cnt_d;
   logic            owned_q, owned_d;

   logic [SELW-1:0] pick_idx_s;
   logic            pick_any_s;
   logic [SELW-1:0] winner_s;
   logic            keep_s;
   logic [3:0]      hold_inc_s;

   rr_pick8 u_pick (
      .req   (bus.req),
      .start (last_sel_q + 3'd1),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // owned_q is cleared on abort so an aborted requester cannot claim continuation of a run.
   assign keep_s     = bus.req[last_sel_q] && owned_q && (hold_cnt_q < MAX_HOLD_C);
   assign winner_s   = keep_s ? last_sel_q : pick_idx_s;
   assign hold_inc_s = (hold_cnt_q == 4'd15) ? 4'd15 : (hold_cnt_q + 4'd1);

   // Next-state, selection and hold bookkeeping.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_sel_d = last_sel_q;
      hold_cnt_d = hold_cnt_q;
      owned_d    = owned_q;
      case (state_q)
         IDLE: begin
            if (pick_any_s) begin
               state_d    = GRANT;
               sel_d      = winner_s;
               hold_cnt_d = (winner_s == last_sel_q) ? hold_inc_s : 4'd1;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (bus.out_ready) begin
               state_d    = IDLE;
               last_sel_d = sel_q;
               owned_d    = 1'b1;
            end else if (!bus.req[sel_q]) begin
               state_d    = IDLE;
               hold_cnt_d = 4'd0;
               owned_d    = 1'b0;
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and bookkeeping registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 3'd0;
         last_sel_q <= 3'd7;
         hold_cnt_q <= 4'd0;
         owned_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_sel_q <= last_sel_d;
         hold_cnt_q <= hold_cnt_d;
         owned_q    <= owned_d;
      end
   end

   assign bus.busy      = (state_q == GRANT);
   assign bus.out_valid = (state_q == GRANT);
   assign bus.sel       = sel_q;
   assign bus.out_data  = (state_q == GRANT) ? bus.din[int'(sel_q)*DW +: DW] : {DW{1'b0}};
   assign bus.gnt       = ((state_q == GRANT) && bus.out_ready) ? (8'b1 << sel_q) : 8'h00;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed scoreboard bench: two arbiters (hold limits 4 and 1) checked by per-instance beat monitors.
module tb_mux8_rr_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mux8_rr_arbiter_if #(.DW(1)) ifa ();
   mux8_rr_arbiter_if #(.DW(1)) ifb ();

   mux8_rr_arbiter #(.DW(1), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mux8_rr_arbiter #(.DW(1), .MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   typedef struct {
      logic [2:0] sel;
      logic       data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [7:0] din_a = 8'hA5;
   logic [7:0] din_b = 8'h3C;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void push(input bit b, input int s);
      exp_t e;
      e.sel  = 3'(s);
      e.data = b ? din_b[s] : din_a[s];
      if (b) qb.push_back(e);
      else   qa.push_back(e);
   endfunction

   // Monitor for instance A: every accepted beat must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && ifa.out_valid && ifa.out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_beat", int'(ifa.out_valid), 0);
         end else begin
            ea = qa.pop_front();
            check("a_sel",  int'(ifa.sel), int'(ea.sel));
            check("a_data", int'(ifa.out_data), int'(ea.data));
            check("a_gnt",  int'(ifa.gnt), 1 << ea.sel);
         end
      end else if (ifa.gnt != 8'h00) begin
         check("a_stray_gnt", int'(ifa.gnt), 0);
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      if (!rst && ifb.out_valid && ifb.out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_beat", int'(ifb.out_valid), 0);
         end else begin
            eb = qb.pop_front();
            check("b_sel",  int'(ifb.sel), int'(eb.sel));
            check("b_data", int'(ifb.out_data), int'(eb.data));
            check("b_gnt",  int'(ifb.gnt), 1 << eb.sel);
         end
      end else if (ifb.gnt != 8'h00) begin
         check("b_stray_gnt", int'(ifb.gnt), 0);
      end
   end

   // Waits (bounded) until the chosen instance pulses gnt; returns at that cycle's negedge.
   task automatic wait_gnt(input bit b, output int cyc);
      bit    got;
      string nm;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         got = b ? (ifb.gnt != 8'h00) : (ifa.gnt != 8'h00);
      end
      nm = b ? "b_gnt_timeout" : "a_gnt_timeout";
      check(nm, int'(got), 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int cyc;
      int seq3[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      int seq4[$] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};

      rst = 1'b1;
      ifa.req = 8'hFF; ifa.din = din_a; ifa.out_ready = 1'b0;
      ifb.req = 8'h00; ifb.din = din_b; ifb.out_ready = 1'b0;

      // Reset held two cycles with all requests up.
      repeat (2) begin
         @(negedge clk);
         check("rst_valid", int'(ifa.out_valid), 0);
         check("rst_gnt",   int'(ifa.gnt), 0);
         check("rst_busy",  int'(ifa.busy), 0);
         check("rst_sel",   int'(ifa.sel), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle_valid", int'(ifa.out_valid), 0);
      @(negedge clk);
      check("post_rst_valid", int'(ifa.out_valid), 1);
      check("post_rst_sel",   int'(ifa.sel), 0);
      push(1'b0, 0);
      @(posedge clk); #1;
      ifa.out_ready = 1'b1;
      wait_gnt(1'b0, cyc);
      @(posedge clk); #1;
      ifa.req = 8'h00;

      // Single requester: beat every other cycle, including past the hold limit.
      do_reset();
      ifa.req = 8'h04;
      for (int i = 0; i < 6; i++) push(1'b0, 2);
      for (int i = 0; i < 6; i++) begin
         wait_gnt(1'b0, cyc);
         check("single_spacing", cyc, 2);
      end
      @(posedge clk); #1;
      ifa.req = 8'h00;

      // Hold limit 4 between requesters 0 and 3.
      do_reset();
      ifa.req = 8'h09;
      foreach (seq4[i]) push(1'b0, seq4[i]);
      foreach (seq4[i]) wait_gnt(1'b0, cyc);
      @(posedge clk); #1;
      ifa.req = 8'h00;

      // Fairness with hold limit 1 on instance B.
      do_reset();
      ifb.req = 8'hFF;
      ifb.out_ready = 1'b1;
      foreach (seq3[i]) push(1'b1, seq3[i]);
      foreach (seq3[i]) wait_gnt(1'b1, cyc);
      @(posedge clk); #1;
      ifb.req = 8'h00;

      // Backpressure: five stalled cycles, then exactly one grant.
      do_reset();
      ifa.out_ready = 1'b0;
      ifa.req = 8'h02;
      @(posedge clk);
      push(1'b0, 1);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", int'(ifa.out_valid), 1);
         check("bp_sel",   int'(ifa.sel), 1);
         check("bp_gnt",   int'(ifa.gnt), 0);
      end
      @(posedge clk); #1;
      ifa.out_ready = 1'b1;
      wait_gnt(1'b0, cyc);
      check("bp_gnt_pulse", int'(ifa.gnt), 8'h02);
      @(posedge clk); #1;
      ifa.req = 8'h00;
      @(negedge clk);
      check("bp_after_valid", int'(ifa.out_valid), 0);
      check("bp_after_gnt",   int'(ifa.gnt), 0);

      // Abort: requester 5 withdraws while stalled.
      ifa.out_ready = 1'b0;
      @(posedge clk); #1;
      ifa.req = 8'h20;
      @(posedge clk);
      @(negedge clk);
      check("abort_sel",   int'(ifa.sel), 5);
      check("abort_valid", int'(ifa.out_valid), 1);
      @(posedge clk); #1;
      ifa.req = 8'h00;
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_after_valid", int'(ifa.out_valid), 0);
      check("abort_after_gnt",   int'(ifa.gnt), 0);
      check("abort_after_busy",  int'(ifa.busy), 0);

      // Reset mid-grant drops the beat.
      @(posedge clk); #1;
      ifa.req = 8'h20;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_sel_before", int'(ifa.sel), 5);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid_sel",   int'(ifa.sel), 0);
      check("rst_mid_valid", int'(ifa.out_valid), 0);
      check("rst_mid_gnt",   int'(ifa.gnt), 0);
      rst = 1'b0;
      ifa.req = 8'h00;
      repeat (2) @(negedge clk);

      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8:1 data multiplexer among 8 requesters. It selects one requester per transfer, drives the mux select, presents the selected data on a valid/ready output port, and returns a one-hot grant pulse when the beat is consumed. A per-requester hold limit bounds consecutive beats so that one source cannot starve the others.

Parameters:
N, 8, number of requesters; fixed at 8 (select width 3).
DW, 1, data width per requester.
MAX_HOLD, 4, max consecutive beats granted to one requester while another is pending; legal range 1..15.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; synchronous, active-high.
req  input  8  per-requester request; held high until the matching gnt bit pulses.
din  input  8*DW  packed requester data; requester i occupies din[i*DW +: DW].
out_ready  input  1  downstream accepts the beat.
out_valid  output  1  beat present on out_data.
out_data  output  DW  din of the selected requester.
sel  output  3  registered mux select (current or last owner).
gnt  output  8  one-hot, high for one cycle when a beat transfers (out_valid && out_ready).
busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, gnt=0, busy=0, sel=0, last_sel=7, hold_cnt=0, out_data=0. After reset, requester 0 has the highest priority.
- There are two states, IDLE and GRANT.
- IDLE:
  - out_valid=0.
  - If req!=0, pick a winner, register sel=winner, and go to GRANT.
  - If req==0, stay in IDLE; sel holds its value.
- Winner selection, evaluated in IDLE:
  - If req[last_sel]=1, hold_cnt<MAX_HOLD, and last_sel owned the previous beat, the winner is last_sel.
  - Otherwise the winner is the first set bit of req scanning last_sel+1, last_sel+2, ... with wrap modulo 8. If only last_sel is requesting, it wins even at the hold limit.
  - hold_cnt becomes hold_cnt+1 if the winner equals last_sel, else 1. It saturates at 15.
- GRANT:
  - busy=1, out_valid=1, out_data=din[sel*DW +: DW]. out_data is combinational from din; it must be stable while out_valid && !out_ready.
  - Transfer when out_ready=1: gnt=(1<<sel) in the same cycle (combinational). last_sel<=sel. Next state is IDLE.
  - out_ready=0: stay in GRANT; sel, out_valid and out_data are unchanged; gnt=0.
  - Abort when req[sel]=0 with no transfer: next state is IDLE, hold_cnt<=0, no gnt.
- Latency: req seen in IDLE at cycle t gives out_valid at t+1. A transfer at cycle t+k gives IDLE at t+k+1, and the next beat is valid at t+k+2. Peak throughput is 1 beat per 2 cycles.
- When not in GRANT: out_data=0 and gnt=0.
- rst asserted in any state, including mid-GRANT with out_ready low, returns all registers to their reset values at the next edge. Any in-flight beat is dropped without gnt.
- Simultaneous events:
  - out_ready=1 and req[sel]=0 in the same cycle: counts as a transfer and gnt pulses.
  - req changes during GRANT on other bits are ignored until the next IDLE.

Decomposition:
- Package mux8_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - constants N=8 and SELW=3;
  - function next_rr(req, start) returning a 3-bit index.
- One sub-module, rr_pick8: a combinational rotate/priority-find. Inputs are req[7:0] and start[2:0]; outputs are idx[2:0] and any.
- The datapath mux is a plain indexed part-select inside the top level.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=8'hFF. Required: out_valid=0, gnt=0, busy=0, sel=0. After rst falls, the first out_valid comes one cycle later with sel=0.
2. Single requester: req=8'h04, din[2]=1, out_ready=1, MAX_HOLD=4. Required: sel=2, out_data=1, gnt=8'h04 every other cycle, indefinitely (no other requester pending).
3. Fairness: MAX_HOLD=1, req=8'hFF held, out_ready=1. Required: the sel sequence over successive beats is 0,1,2,3,4,5,6,7,0, and the gnt bits match.
4. Hold limit: MAX_HOLD=4, req=8'h09 held, out_ready=1. Required: sel beats are 0,0,0,0,3,3,3,3,0.
5. Backpressure: req=8'h02, out_ready=0 for 5 cycles, then 1. Required: out_valid=1 and sel=1 stable with gnt=0 for 5 cycles, then gnt=8'h02 for exactly one cycle, then out_valid=0.
6. Abort and reset mid-operation:
   - In GRANT with sel=5, drop req[5] while out_ready=0. Required: out_valid=0 the next cycle and no gnt.
   - Repeat, but assert rst instead. Required: sel=0 and out_valid=0 the next cycle.
